wb_arbiter: RTL and testbench

Round-robin writeback arbiter sharing the register file's single write port (WE3/A3/WD3) between the core's writeback sources: ALU, load/store unit and multiply/divide unit. It sits between the execute/memory stages and the register file. It accepts at most one write per cycle over valid/ready handshakes and drives a registered write port. It also keeps a saturating conflict statistic and, optionally, forwards the in-flight write to the operand read path.

---
 rtl/wb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and requester indices for the writeback arbiter slice.
// Purely declarative: no logic, no latency.
package wb_pkg;
    localparam int DEF_NREQ = 3;
    localparam int DEF_XLEN = 64;
    localparam int DEF_AW   = 5;
    localparam int CNT_W    = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LSU  = 1;
    localparam int REQ_MDU  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin grant: search starts after last_i and wraps; one-hot output.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o
);
    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter onto a registered single RF write port (1-cycle latency).
// Optional operand forwarding of the in-flight write under macro WB_BYPASS_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*XLEN-1:0] req_data_i,
    output logic                 rf_we_o,
    output logic [AW-1:0]        rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    input  logic                 clr_stats_i,
    output logic [CNT_W-1:0]     conflict_cnt_o,
    input  logic [AW-1:0]        byp_addr1_i,
    input  logic [AW-1:0]        byp_addr2_i,
    output logic                 byp_hit1_o,
    output logic                 byp_hit2_o,
    output logic [XLEN-1:0]      byp_data1_o,
    output logic [XLEN-1:0]      byp_data2_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic             xfer;
    logic             conflict;
    logic [AW-1:0]    sel_addr;
    logic [XLEN-1:0]  sel_data;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Masking requests during reset keeps every handshake closed while rst_i is high.
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i     (req_valid_i & {NREQ{~rst_i}}),
        .last_i    (last_grant_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign xfer        = |gnt;
    assign conflict    = ($countones(req_valid_i) >= 2);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | req_addr_i[i*AW +: AW];
                sel_data = sel_data | req_data_i[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (xfer) begin
            last_grant_d = gnt_idx;
            rf_we_d      = (sel_addr != '0);
            rf_waddr_d   = sel_addr;
            rf_wdata_d   = sel_data;
        end
        cnt_d = cnt_q;
        if (clr_stats_i)
            cnt_d = '0;
        else if (conflict && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= IW'(NREQ - 1);
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign conflict_cnt_o = cnt_q;

`ifdef WB_BYPASS_EN
    assign byp_hit1_o  = rf_we_q && (rf_waddr_q == byp_addr1_i);
    assign byp_hit2_o  = rf_we_q && (rf_waddr_q == byp_addr2_i);
    assign byp_data1_o = byp_hit1_o ? rf_wdata_q : '0;
    assign byp_data2_o = byp_hit2_o ? rf_wdata_q : '0;
`else
    logic byp_unused;
    assign byp_unused  = ^{byp_addr1_i, byp_addr2_i};
    assign byp_hit1_o  = 1'b0;
    assign byp_hit2_o  = 1'b0;
    assign byp_data1_o = '0;
    assign byp_data2_o = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*XLEN-1:0] req_data_i;
    logic                 rf_we_o;
    logic [AW-1:0]        rf_waddr_o;
    logic [XLEN-1:0]      rf_wdata_o;
    logic                 clr_stats_i;
    logic [15:0]          conflict_cnt_o;
    logic [AW-1:0]        byp_addr1_i, byp_addr2_i;
    logic                 byp_hit1_o, byp_hit2_o;
    logic [XLEN-1:0]      byp_data1_o, byp_data2_o;

    wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .clr_stats_i(clr_stats_i), .conflict_cnt_o(conflict_cnt_o),
        .byp_addr1_i(byp_addr1_i), .byp_addr2_i(byp_addr2_i),
        .byp_hit1_o(byp_hit1_o), .byp_hit2_o(byp_hit2_o),
        .byp_data1_o(byp_data1_o), .byp_data2_o(byp_data2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [15:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: what the write port and counter must show after each cycle.
    int              m_last = NREQ - 1;
    logic            m_we   = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [XLEN-1:0] m_data = '0;
    logic [15:0]     m_cnt  = '0;
    int              last_gi;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check the grant, advance the model, queue the expected write port.
    task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                       input logic [NREQ*XLEN-1:0] d, input logic clr, input logic rst,
                       input logic [AW-1:0] b1, input logic [AW-1:0] b2);
        int gi;
        int j;
        int nv;
        logic [NREQ-1:0] exp_rdy;
        @(posedge clk_i); #1;
        req_valid_i = v; req_addr_i = a; req_data_i = d;
        clr_stats_i = clr; rst_i = rst;
        byp_addr1_i = b1; byp_addr2_i = b2;
        @(negedge clk_i);
        gi = -1;
        if (!rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_last + k) % NREQ;
                if (gi < 0 && v[j]) gi = j;
            end
        end
        exp_rdy = '0;
        if (gi >= 0) exp_rdy[gi] = 1'b1;
        chk("req_ready", XLEN'(req_ready_o), XLEN'(exp_rdy));
        last_gi = gi;
        nv = 0;
        for (int k = 0; k < NREQ; k++) nv += int'(v[k]);
        if (rst) begin
            m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0; m_last = NREQ - 1;
        end else begin
            if (gi >= 0) begin
                m_addr = a[gi*AW +: AW];
                m_data = d[gi*XLEN +: XLEN];
                m_we   = (m_addr != 0);
                m_last = gi;
            end else begin
                m_we = 1'b0;
            end
            if (clr) m_cnt = '0;
            else if (nv >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        exp_q.push_back('{we: m_we, addr: m_addr, data: m_data, cnt: m_cnt});
    endtask

    // Monitor: after each edge, the registered port must match the oldest queued expectation.
    initial begin
        exp_t e;
        logic eh1, eh2;
        forever begin
            @(posedge clk_i); #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", XLEN'(rf_we_o), XLEN'(e.we));
                chk("rf_waddr", XLEN'(rf_waddr_o), XLEN'(e.addr));
                chk("rf_wdata", rf_wdata_o, e.data);
                chk("conflict_cnt", XLEN'(conflict_cnt_o), XLEN'(e.cnt));
`ifdef WB_BYPASS_EN
                eh1 = e.we && (e.addr == byp_addr1_i);
                eh2 = e.we && (e.addr == byp_addr2_i);
`else
                eh1 = 1'b0;
                eh2 = 1'b0;
`endif
                chk("byp_hit1", XLEN'(byp_hit1_o), XLEN'(eh1));
                chk("byp_hit2", XLEN'(byp_hit2_o), XLEN'(eh2));
                chk("byp_data1", byp_data1_o, eh1 ? e.data : '0);
                chk("byp_data2", byp_data2_o, eh2 ? e.data : '0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ*AW-1:0]   a;
        logic [NREQ*XLEN-1:0] d;
        logic [NREQ-1:0]      v;
        int                   seq[6];
        int                   exp_seq[6] = '{0, 1, 2, 0, 1, 2};
        logic [AW-1:0]        b1;
        rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
        clr_stats_i = 1'b0; byp_addr1_i = '0; byp_addr2_i = '0;

        // Reset with every requester pushing.
        a = {5'd3, 5'd2, 5'd1};
        d = {64'h33, 64'h22, 64'h11};
        repeat (2) begin
            cyc(3'b111, a, d, 1'b0, 1'b1, 5'd0, 5'd0);
            chk("reset_ready", XLEN'(req_ready_o), 64'd0);
        end

        // Continuous contention: strict rotation starting at requester 0.
        for (int i = 0; i < 6; i++) begin
            cyc(3'b111, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
            seq[i] = last_gi;
        end
        for (int i = 0; i < 6; i++) chk("rr_order", XLEN'(seq[i]), XLEN'(exp_seq[i]));
        cyc(3'b000, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("rr_conflicts", XLEN'(conflict_cnt_o), 64'd6);

        // Single ALU write, visible for exactly one cycle.
        a = {5'd0, 5'd0, 5'd5};
        d = {64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001};
        cyc(3'b001, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("single_ready", XLEN'(req_ready_o), 64'd1);
        cyc(3'b000, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("single_we", XLEN'(rf_we_o), 64'd1);
        chk("single_addr", XLEN'(rf_waddr_o), 64'd5);
        chk("single_data", rf_wdata_o, 64'hDEAD_BEEF_0000_0001);
        cyc(3'b000, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("single_we_drop", XLEN'(rf_we_o), 64'd0);

        // x0 write from LSU: accepted, discarded, pointer moves past LSU.
        a = {5'd9, 5'd0, 5'd4};
        d = {64'h99, 64'h55, 64'h44};
        cyc(3'b010, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("x0_ready", XLEN'(req_ready_o), 64'd2);
        cyc(3'b111, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("x0_we", XLEN'(rf_we_o), 64'd0);
        chk("x0_next_grant", XLEN'(req_ready_o), 64'd4);

        // Forwarding of the in-flight write.
        a = {5'd0, 5'd0, 5'd7};
        d = {64'h0, 64'h0, 64'h1234};
        cyc(3'b001, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(3'b000, a, d, 1'b0, 1'b0, 5'd7, 5'd8);
`ifdef WB_BYPASS_EN
        chk("byp_dir_hit1", XLEN'(byp_hit1_o), 64'd1);
        chk("byp_dir_data1", byp_data1_o, 64'h1234);
`else
        chk("byp_dir_hit1", XLEN'(byp_hit1_o), 64'd0);
        chk("byp_dir_data1", byp_data1_o, 64'd0);
`endif
        chk("byp_dir_hit2", XLEN'(byp_hit2_o), 64'd0);

        // Saturation of the conflict counter, then clear colliding with a conflict.
        for (int i = 0; i < 70000; i++)
            cyc(3'b011, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        cyc(3'b111, a, d, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("cnt_saturated", XLEN'(conflict_cnt_o), 64'hFFFF);
        cyc(3'b000, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("cnt_cleared", XLEN'(conflict_cnt_o), 64'd0);

        // Randomized traffic including x0 targets, clears and occasional mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            v = NREQ'($urandom_range(0, 7));
            for (int r = 0; r < NREQ; r++) begin
                a[r*AW +: AW]     = AW'($urandom_range(0, 31));
                d[r*XLEN +: XLEN] = {$urandom, $urandom};
            end
            b1 = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom_range(0, 31));
            cyc(v, a, d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0),
                b1, AW'($urandom_range(0, 31)));
        end
        cyc(3'b000, a, d, 1'b0, 1'b0, 5'd0, 5'd0);
        @(posedge clk_i); #4;
        chk("queue_drained", XLEN'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
